buzzer_note_decoder: RTL and testbench
======================================

# buzzer_note_decoder

Measures the period of a square-wave tone input and classifies it as one of the seven scale notes DO–XI that the buzzer player emits. It is the receive side of the buzzer tone interface: it sits on a looped-back buzzer line or an external tone source and reports which note is sounding. A change of note is reported only after several consecutive matching periods, and silence is reported after a timeout.

## Interface
- DO, 18'd19083, period of note 1 in system_clock cycles
- RE, 18'd17006, period of note 2
- MI, 18'd15151, period of note 3
- FA, 18'd14326, period of note 4
- SO, 18'd12755, period of note 5
- LA, 18'd11363, period of note 6
- XI, 18'd10121, period of note 7
- TOLERANCE, 18'd256, maximum allowed absolute deviation of a measured period from a note period
- STABLE_COUNT, 3, number of consecutive identical classifications required before the output changes (range 1..7)
- TIMEOUT, 18'd40000, number of cycles without a rising edge after which the tone is declared silent; must be > DO + TOLERANCE and < 2^18
- system_clock  input  1  single clock for the whole block
- system_reset_n  input  1  asynchronous, active-low reset
- tone_in  input  1  asynchronous square-wave tone; any duty cycle
- note_code  output  3  0 = silence/none, 1..7 = DO..XI
- note_valid  output  1  one-cycle pulse whenever note_code changes
- note_active  output  1  high when note_code != 0
- period_out  output  18  last measured period, for debug

## Operation
- tone_in is synchronized through two flops. A third flop holds the previous synchronized value. A rising edge is flagged when sync = 1 and prev = 0.
- 18-bit cycle counter: cleared on each rising edge, otherwise increments, saturating at TIMEOUT.
- Measurement FSM:
  - IDLE: no reference edge. The first edge moves the FSM to MEASURE and produces no sample.
  - MEASURE: on each edge, sample = counter + 1. The sample is latched into period_out and the FSM stays in MEASURE.
  - On counter == TIMEOUT, the FSM returns to IDLE.
- Classification of each sample:
  - The candidate is the lowest note k with |sample − P_k| <= TOLERANCE. If no note matches, the candidate is 0.
  - Use unsigned subtraction with the larger operand first, so no signed arithmetic is needed.
- Stability tracking:
  - If candidate == previous candidate, stable_cnt increments, saturating at STABLE_COUNT.
  - Otherwise stable_cnt = 1 and the previous candidate is updated.
- Output update:
  - When stable_cnt == STABLE_COUNT and candidate != note_code, load note_code and pulse note_valid.
  - A stable non-matching stream (candidate 0) therefore also drives note_code to 0.
- Timeout:
  - Entering IDLE clears the previous candidate and stable_cnt.
  - If note_code != 0, note_code is set to 0 with a note_valid pulse.
- Reset values (all outputs and state): note_code 0, note_valid 0, note_active 0, period_out 0, FSM IDLE, counter 0, stable_cnt 0.
- Reset is asynchronous and takes effect mid-measurement. After release, the first edge only re-arms the FSM.

## Timing
- tone_in rise to edge flag: 2–3 system_clock edges (synchronizer).
- Edge flag cycle: sample computed and period_out registered.
- +1 cycle: candidate and stable_cnt registered.
- +2 cycles: note_code, note_active and note_valid updated.
- A steady tone is reported on the (STABLE_COUNT + 1)-th rising edge, plus the 2-cycle pipeline delay.
- An edge and the timeout in the same cycle: the edge wins, the counter clears and the FSM stays in MEASURE.
- Counter saturation: once the counter reaches TIMEOUT, it holds there until the next edge.
- note_valid is never asserted on two consecutive cycles except by real consecutive changes, which cannot occur because the minimum period far exceeds the pipeline depth.

## Structure
- Shared package buzzer_pkg holds:
  - note code constants NOTE_NONE = 3'd0, NOTE_DO = 3'd1 … NOTE_XI = 3'd7;
  - the default note period constants, shared with the buzzer player.
- One sub-module, tone_edge_detect: 2-flop synchronizer plus rising-edge pulse, reusable by other tone inputs.
- Period counter, FSM and classifier stay in buzzer_note_decoder.

## Test plan
- Reset, then 5 periods of 15151 cycles at 50% duty -> note_code = 3, a single note_valid pulse after the 4th rising edge, note_active = 1, period_out = 15151.
- Stream of DO periods at 19083 + 200 -> note_code = 1. Stream at 19083 + 300 -> after 3 samples note_code = 0 with a note_valid pulse.
- Locked on MI, switch to 12755-cycle periods -> note_code changes 3 to 5 after 3 SO periods, exactly one pulse.
- Locked on LA, one glitch period of 5000 cycles inserted -> note_code stays 6 and no note_valid pulse.
- Locked on XI, hold tone_in low -> 40000 cycles after the last edge, note_code = 0, note_active = 0, one pulse. A restarted tone needs 4 edges to report again.
- Assert system_reset_n low mid-period while locked -> all outputs 0 immediately. After release, the first edge produces no sample.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared constants for the buzzer tone interface: note codes, default note periods
// and the default timing parameters of the note decoder.
package buzzer_pkg;

    localparam int PERIOD_W  = 18;
    localparam int NUM_NOTES = 7;

    localparam logic [2:0] NOTE_NONE = 3'd0;
    localparam logic [2:0] NOTE_DO   = 3'd1;
    localparam logic [2:0] NOTE_RE   = 3'd2;
    localparam logic [2:0] NOTE_MI   = 3'd3;
    localparam logic [2:0] NOTE_FA   = 3'd4;
    localparam logic [2:0] NOTE_SO   = 3'd5;
    localparam logic [2:0] NOTE_LA   = 3'd6;
    localparam logic [2:0] NOTE_XI   = 3'd7;

    localparam logic [PERIOD_W-1:0] PERIOD_DO = 18'd19083;
    localparam logic [PERIOD_W-1:0] PERIOD_RE = 18'd17006;
    localparam logic [PERIOD_W-1:0] PERIOD_MI = 18'd15151;
    localparam logic [PERIOD_W-1:0] PERIOD_FA = 18'd14326;
    localparam logic [PERIOD_W-1:0] PERIOD_SO = 18'd12755;
    localparam logic [PERIOD_W-1:0] PERIOD_LA = 18'd11363;
    localparam logic [PERIOD_W-1:0] PERIOD_XI = 18'd10121;

    // Note k (1..7) lives in slice [(k-1)*PERIOD_W +: PERIOD_W].
    localparam logic [NUM_NOTES*PERIOD_W-1:0] DEFAULT_PERIODS = {
        PERIOD_XI, PERIOD_LA, PERIOD_SO, PERIOD_FA, PERIOD_MI, PERIOD_RE, PERIOD_DO
    };

    localparam logic [PERIOD_W-1:0] DEFAULT_TOLERANCE    = 18'd256;
    localparam int                  DEFAULT_STABLE_COUNT = 3;
    localparam logic [PERIOD_W-1:0] DEFAULT_TIMEOUT      = 18'd40000;

    typedef enum logic {
        MEAS_IDLE,
        MEAS_RUN
    } meas_state_t;

    function automatic logic [PERIOD_W-1:0] abs_diff(
        input logic [PERIOD_W-1:0] a,
        input logic [PERIOD_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/buzzer_note_decoder_if.sv
// Tone input and decoded-note outputs of the buzzer note decoder.
interface buzzer_note_decoder_if;

    logic                          tone_in;
    logic [2:0]                    note_code;
    logic                          note_valid;
    logic                          note_active;
    logic [buzzer_pkg::PERIOD_W-1:0] period_out;

    modport master (
        input  tone_in,
        output note_code,
        output note_valid,
        output note_active,
        output period_out
    );

    modport slave (
        output tone_in,
        input  note_code,
        input  note_valid,
        input  note_active,
        input  period_out
    );

endinterface

// File: rtl/buzzer_note_decoder_tone_edge_detect.sv
// Two-flop synchronizer for an asynchronous tone line plus a one-cycle rising-edge pulse.
module tone_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic tone,
    output logic rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= tone;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign rise = sync2_reg & ~prev_reg;

endmodule

// File: rtl/buzzer_note_decoder.sv
// Measures the period of the tone input, classifies it as DO..XI and reports a note
// once it has been seen on several consecutive periods; reports silence after a timeout.
module buzzer_note_decoder
    import buzzer_pkg::*;
#(
    parameter logic [NUM_NOTES*PERIOD_W-1:0] PERIODS      = DEFAULT_PERIODS,
    parameter logic [PERIOD_W-1:0]           TOLERANCE    = DEFAULT_TOLERANCE,
    parameter int                            STABLE_COUNT = DEFAULT_STABLE_COUNT,
    parameter logic [PERIOD_W-1:0]           TIMEOUT      = DEFAULT_TIMEOUT
) (
    input  logic                  system_clock,
    input  logic                  system_reset_n,
    buzzer_note_decoder_if.master bus
);

    localparam logic [2:0] STABLE_MAX = 3'(STABLE_COUNT);

    logic                edge_flag;
    meas_state_t         state_reg;
    logic [PERIOD_W-1:0] counter_reg;
    logic [PERIOD_W-1:0] period_reg;
    logic                sample_valid_reg;
    logic                timeout_reg;

    logic [NUM_NOTES-1:0] match;
    logic [2:0]           candidate;
    logic [2:0]           prev_cand_reg;
    logic [2:0]           stable_cnt_reg;
    logic                 clear_reg;

    logic [2:0] note_code_reg;
    logic       note_valid_reg;
    logic       note_active_reg;

    tone_edge_detect u_edge (
        .clk   (system_clock),
        .rst_n (system_reset_n),
        .tone  (bus.tone_in),
        .rise  (edge_flag)
    );

    // Stage 1: period counter and measurement FSM; an edge always beats the timeout.
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_reg        <= MEAS_IDLE;
            counter_reg      <= '0;
            period_reg       <= '0;
            sample_valid_reg <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            sample_valid_reg <= 1'b0;
            timeout_reg      <= 1'b0;
            if (edge_flag) begin
                counter_reg <= '0;
            end else if (counter_reg != TIMEOUT) begin
                counter_reg <= counter_reg + 1'b1;
            end
            case (state_reg)
                MEAS_IDLE: begin
                    if (edge_flag) begin
                        state_reg <= MEAS_RUN;
                    end
                end
                MEAS_RUN: begin
                    if (edge_flag) begin
                        period_reg       <= counter_reg + 1'b1;
                        sample_valid_reg <= 1'b1;
                    end else if (counter_reg == TIMEOUT) begin
                        state_reg   <= MEAS_IDLE;
                        timeout_reg <= 1'b1;
                    end
                end
                default: state_reg <= MEAS_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_match
            assign match[gi] =
                abs_diff(period_reg, PERIODS[gi*PERIOD_W +: PERIOD_W]) <= TOLERANCE;
        end
    endgenerate

    // Scan from the top so the lowest matching note wins.
    always_comb begin
        candidate = NOTE_NONE;
        for (int k = NUM_NOTES - 1; k >= 0; k--) begin
            if (match[k]) begin
                candidate = 3'(k + 1);
            end
        end
    end

    // Stage 2: count consecutive identical classifications.
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            prev_cand_reg  <= NOTE_NONE;
            stable_cnt_reg <= '0;
            clear_reg      <= 1'b0;
        end else begin
            clear_reg <= 1'b0;
            if (timeout_reg) begin
                prev_cand_reg  <= NOTE_NONE;
                stable_cnt_reg <= '0;
                clear_reg      <= 1'b1;
            end else if (sample_valid_reg) begin
                if (candidate == prev_cand_reg) begin
                    if (stable_cnt_reg != STABLE_MAX) begin
                        stable_cnt_reg <= stable_cnt_reg + 1'b1;
                    end
                end else begin
                    prev_cand_reg  <= candidate;
                    stable_cnt_reg <= 3'd1;
                end
            end
        end
    end

    // Stage 3: publish a change of note, or silence after a timeout.
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            note_code_reg   <= NOTE_NONE;
            note_valid_reg  <= 1'b0;
            note_active_reg <= 1'b0;
        end else begin
            note_valid_reg <= 1'b0;
            if (clear_reg) begin
                if (note_code_reg != NOTE_NONE) begin
                    note_code_reg   <= NOTE_NONE;
                    note_active_reg <= 1'b0;
                    note_valid_reg  <= 1'b1;
                end
            end else if (stable_cnt_reg == STABLE_MAX && prev_cand_reg != note_code_reg) begin
                note_code_reg   <= prev_cand_reg;
                note_active_reg <= (prev_cand_reg != NOTE_NONE);
                note_valid_reg  <= 1'b1;
            end
        end
    end

    assign bus.note_code   = note_code_reg;
    assign bus.note_valid  = note_valid_reg;
    assign bus.note_active = note_active_reg;
    assign bus.period_out  = period_reg;

endmodule

// File: tb/tb_buzzer_note_decoder.sv
// Self-checking bench for buzzer_note_decoder with note periods scaled down by 32
// so that every scenario fits in a short run.
module tb_buzzer_note_decoder;

    localparam int TOL    = 8;
    localparam int TMO    = 1250;
    localparam int STABLE = 3;

    int p_tab [8] = '{0, 596, 531, 473, 447, 398, 355, 316};

    typedef struct {
        int len;
        int count;
        int exp_code;
        int exp_pulses;
    } seg_t;

    logic clk = 1'b0;
    logic rst_n;

    buzzer_note_decoder_if nd_if ();

    buzzer_note_decoder #(
        .PERIODS      ({18'd316, 18'd355, 18'd398, 18'd447, 18'd473, 18'd531, 18'd596}),
        .TOLERANCE    (18'(TOL)),
        .STABLE_COUNT (STABLE),
        .TIMEOUT      (18'(TMO))
    ) dut (
        .system_clock   (clk),
        .system_reset_n (rst_n),
        .bus            (nd_if)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;

    always @(negedge clk) begin
        if (nd_if.note_valid === 1'b1) pulse_cnt++;
    end

    // Reference model state, updated at each tone rising edge the bench drives.
    bit   armed = 1'b0;
    int   hist[$];
    int   note_m = 0;
    int   pout_m = 0;
    int   pulses_m = 0;
    int   gap_acc = 0;

    function automatic int classify(input int s);
        for (int k = 1; k <= 7; k++) begin
            int d;
            d = (s > p_tab[k]) ? s - p_tab[k] : p_tab[k] - s;
            if (d <= TOL) return k;
        end
        return 0;
    endfunction

    task automatic model_edge();
        int c;
        bit same;
        if (!armed) begin
            armed = 1'b1;
        end else begin
            pout_m = gap_acc;
            c = classify(gap_acc);
            hist.push_back(c);
            if (hist.size() >= STABLE) begin
                same = 1'b1;
                for (int i = 1; i < STABLE; i++)
                    if (hist[hist.size() - 1 - i] != c) same = 1'b0;
                if (same && c != note_m) begin
                    note_m = c;
                    pulses_m++;
                end
            end
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        #1;
        check({tag, "_code"},   int'(nd_if.note_code),   note_m);
        check({tag, "_active"}, int'(nd_if.note_active), (note_m != 0) ? 1 : 0);
        check({tag, "_period"}, int'(nd_if.period_out),  pout_m);
        check({tag, "_pulses"}, pulse_cnt,               pulses_m);
    endtask

    task automatic tone_period(input int len);
        int h;
        h = len / 2;
        nd_if.tone_in = 1'b1;
        model_edge();
        gap_acc = 0;
        repeat (h) @(negedge clk);
        nd_if.tone_in = 1'b0;
        repeat (len - h) @(negedge clk);
        gap_acc = len;
        check_state("period");
    endtask

    task automatic silence(input int n);
        repeat (n) @(negedge clk);
        gap_acc += n;
        if (armed && gap_acc >= TMO + 2) begin
            armed = 1'b0;
            hist.delete();
            if (note_m != 0) begin
                note_m = 0;
                pulses_m++;
            end
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        seg_t segs[$];
        int p0;

        // Boundary and scenario table: samples lag one period behind the drive.
        segs.push_back(seg_t'{473, 5, 3, 1});  // MI lock after 4th edge
        segs.push_back(seg_t'{602, 4, 1, 1});  // DO + 6, inside tolerance
        segs.push_back(seg_t'{606, 4, 0, 1});  // DO + 10, outside -> none
        segs.push_back(seg_t'{604, 4, 1, 1});  // DO + TOL exactly
        segs.push_back(seg_t'{587, 4, 0, 1});  // DO - TOL - 1
        segs.push_back(seg_t'{473, 4, 3, 1});
        segs.push_back(seg_t'{398, 4, 5, 1});  // MI -> SO
        segs.push_back(seg_t'{355, 4, 6, 1});
        segs.push_back(seg_t'{156, 1, 6, 0});  // glitch period
        segs.push_back(seg_t'{355, 4, 6, 0});
        segs.push_back(seg_t'{316, 4, 7, 1});

        nd_if.tone_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_code",   int'(nd_if.note_code),   0);
        check("reset_valid",  int'(nd_if.note_valid),  0);
        check("reset_active", int'(nd_if.note_active), 0);
        check("reset_period", int'(nd_if.period_out),  0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int s = 0; s < segs.size(); s++) begin
            p0 = pulse_cnt;
            for (int n = 0; n < segs[s].count; n++) tone_period(segs[s].len);
            $display("[TB] seg %0d len %0d x%0d -> code %0d pulses %0d",
                     s, segs[s].len, segs[s].count, nd_if.note_code, pulse_cnt - p0);
            check("seg_code",   int'(nd_if.note_code), segs[s].exp_code);
            check("seg_pulses", pulse_cnt - p0,        segs[s].exp_pulses);
        end

        // Silence: XI still held just before the timeout, cleared just after.
        p0 = pulse_cnt;
        silence(TMO - 1 - gap_acc);
        #1;
        check("pre_timeout_code", int'(nd_if.note_code), 7);
        silence(20);
        #1;
        $display("[TB] silence -> code %0d active %0d", nd_if.note_code, nd_if.note_active);
        check("timeout_code",   int'(nd_if.note_code),   0);
        check("timeout_active", int'(nd_if.note_active), 0);
        check("timeout_pulses", pulse_cnt - p0,          1);
        check_state("timeout");

        // Restarted tone needs four edges before it is reported.
        for (int n = 0; n < 3; n++) tone_period(316);
        check("restart3_code", int'(nd_if.note_code), 0);
        tone_period(316);
        $display("[TB] restart -> code %0d", nd_if.note_code);
        check("restart4_code", int'(nd_if.note_code), 7);

        // Reset in the middle of a locked period.
        nd_if.tone_in = 1'b1;
        model_edge();
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        armed = 1'b0;
        hist.delete();
        note_m = 0;
        pout_m = 0;
        #1;
        $display("[TB] mid-period reset -> code %0d period %0d", nd_if.note_code, nd_if.period_out);
        check("midrst_code",   int'(nd_if.note_code),   0);
        check("midrst_valid",  int'(nd_if.note_valid),  0);
        check("midrst_active", int'(nd_if.note_active), 0);
        check("midrst_period", int'(nd_if.period_out),  0);
        @(negedge clk);
        nd_if.tone_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        tone_period(316);
        check("rearm_period", int'(nd_if.period_out), 0);
        tone_period(316);
        check("first_sample", int'(nd_if.period_out), 316);

        // Randomised runs of notes and off-scale periods.
        for (int s = 0; s < 10; s++) begin
            int k;
            int runlen;
            int len;
            k = int'($urandom_range(0, 7));
            runlen = int'($urandom_range(1, 4));
            for (int n = 0; n < runlen; n++) begin
                if (k > 0) len = p_tab[k] + int'($urandom_range(0, 2 * TOL)) - TOL;
                else       len = int'($urandom_range(150, 700));
                tone_period(len);
            end
            $display("[TB] random seg %0d note %0d x%0d -> code %0d expected %0d",
                     s, k, runlen, nd_if.note_code, note_m);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
